// File: rtl/note_led_driver_if.sv
// Note-source <-> LED-driver bundle: note/mode in, LED drive and new-note pulse out.
// The source side (keyboard/song logic or a bench) takes the master modport.
interface note_led_driver_if #(
  parameter int NUM_NOTES = 7,
  parameter int NOTE_W    = 4
);
  logic [NOTE_W-1:0]    song_note;
  logic [1:0]           mode;
  logic [NUM_NOTES-1:0] led_code;
  logic                 note_change;

  modport master (output song_note, mode, input  led_code, note_change);
  modport slave  (input  song_note, mode, output led_code, note_change);
endinterface

// File: rtl/note_led_driver.sv
// Registered note-to-LED driver: one-hot, bar, afterglow hold and idle chase modes,
// plus a one-cycle pulse whenever a new valid note arrives.
module note_led_driver #(
  parameter int NUM_NOTES   = 7,
  parameter int NOTE_W      = 4,
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int IDLE_CYCLES = 100_000_000,
  parameter int STEP_CYCLES = 10_000_000
) (
  input logic              clk,
  input logic              rst_n,
  note_led_driver_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_BAR    = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);

  localparam logic [NOTE_W-1:0]    NOTE_MAX  = NOTE_W'(NUM_NOTES);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [IDLE_W-1:0]    IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [NUM_NOTES-1:0] POS_MSB   = {1'b1, {(NUM_NOTES-1){1'b0}}};

  logic [NOTE_W-1:0]    note_d, note_q, note_prev_q;
  logic [HOLD_W-1:0]    hold_d [NUM_NOTES];
  logic [HOLD_W-1:0]    hold_q [NUM_NOTES];
  logic [IDLE_W-1:0]    idle_d, idle_q;
  logic [STEP_W-1:0]    step_d, step_q;
  logic [NUM_NOTES-1:0] pos_d, pos_q;
  logic [NUM_NOTES-1:0] led_d, led_q;
  logic                 change_d, change_q;

  logic [NUM_NOTES-1:0] onehot, bar, hold_lit;
  logic                 rest, chase_active;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    onehot = '0;
    bar    = '0;
    note_d = (bus.song_note > NOTE_MAX) ? '0 : bus.song_note;
    for (int k = 1; k <= NUM_NOTES; k++) begin
      if (note_q == NOTE_W'(k)) onehot[NUM_NOTES-k] = 1'b1;
      if (note_q >= NOTE_W'(k)) bar[NUM_NOTES-k]    = 1'b1;
    end

    // An LED is lit on the cycle its note is decoded and while its counter drains.
    for (int i = 0; i < NUM_NOTES; i++) begin
      hold_lit[i] = onehot[i] | (hold_q[i] != '0);
      if (onehot[i])            hold_d[i] = HOLD_LOAD;
      else if (hold_q[i] != '0) hold_d[i] = hold_q[i] - HOLD_W'(1);
      else                      hold_d[i] = '0;
    end

    rest         = (note_q == '0);
    chase_active = rest && (idle_q == IDLE_MAX);

    idle_d = idle_q;
    step_d = step_q;
    pos_d  = pos_q;
    if (!rest) begin
      idle_d = '0;
      step_d = '0;
      pos_d  = POS_MSB;
    end else begin
      if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
      if (chase_active) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          pos_d  = pos_q[0] ? POS_MSB : (pos_q >> 1);
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
    end

    case (mode_e'(bus.mode))
      MODE_ONEHOT: led_d = onehot;
      MODE_BAR:    led_d = bar;
      MODE_HOLD:   led_d = hold_lit;
      MODE_CHASE:  led_d = chase_active ? pos_q : onehot;
      default:     led_d = onehot;
    endcase

    change_d = !rest && (note_q != note_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q      <= '0;
      note_prev_q <= '0;
      idle_q      <= '0;
      step_q      <= '0;
      pos_q       <= POS_MSB;
      led_q       <= '0;
      change_q    <= '0;
      // NOTE: the hold counters are individual flops, not a RAM, so they take the async reset.
      for (int i = 0; i < NUM_NOTES; i++) hold_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      note_q      <= note_d;
      note_prev_q <= note_q;
      idle_q      <= idle_d;
      step_q      <= step_d;
      pos_q       <= pos_d;
      led_q       <= led_d;
      change_q    <= change_d;
      for (int i = 0; i < NUM_NOTES; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign bus.led_code    = led_q;
  assign bus.note_change = change_q;

endmodule

// File: tb/tb_note_led_driver.sv
// Self-checking bench for note_led_driver: a history-based reference model pushes the
// expected LED word and pulse per driven note; the checker pops them as the DUT outputs.
module tb_note_led_driver;

  localparam int NN    = 7;
  localparam int NW    = 4;
  localparam int HOLD  = 4;
  localparam int IDLE  = 8;
  localparam int STEP  = 2;

  typedef struct {
    logic [NN-1:0] led;
    logic          nc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  note_led_driver_if #(.NUM_NOTES(NN), .NOTE_W(NW)) bus ();

  note_led_driver #(
    .NUM_NOTES  (NN),
    .NOTE_W     (NW),
    .HOLD_CYCLES(HOLD),
    .IDLE_CYCLES(IDLE),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t  sb_q[$];
  int    hist_q[$];
  int    run_len;
  int    prev_note;
  int    mode_next;
  int    edge_cnt;
  int    tests_run;
  int    tests_failed;
  string cur_test;

  // Expected output for note_q value n, displayed in mode m, derived from note history.
  function automatic void push_model(input int n, input int m);
    exp_t e;
    int onehot, bar, hold, chase, k;
    hist_q.push_back(n);
    if (hist_q.size() > HOLD + 1) void'(hist_q.pop_front());
    run_len = (n == 0) ? run_len + 1 : 0;
    onehot  = (n == 0) ? 0 : (1 << (NN - n));
    bar     = (n == 0) ? 0 : (((1 << n) - 1) << (NN - n));
    hold    = 0;
    foreach (hist_q[i]) if (hist_q[i] != 0) hold |= (1 << (NN - hist_q[i]));
    chase   = onehot;
    if (n == 0 && run_len >= IDLE + 1) begin
      k     = ((run_len - IDLE - 1) / STEP) % NN;
      chase = 1 << (NN - 1 - k);
    end
    case (m)
      0:       e.led = NN'(onehot);
      1:       e.led = NN'(bar);
      2:       e.led = NN'(hold);
      default: e.led = NN'(chase);
    endcase
    e.nc      = (n != 0) && (n != prev_note);
    prev_note = n;
    sb_q.push_back(e);
  endfunction

  // One clock: drive note (display mode m), advance, then check the output due this edge.
  task automatic step(input int note, input int m);
    exp_t e;
    bus.mode      = 2'(mode_next);
    mode_next     = m;
    bus.song_note = NW'(note);
    push_model((note > NN) ? 0 : note, m);
    @(posedge clk);
    #1;
    edge_cnt++;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s scoreboard_empty edge %0d", cur_test, edge_cnt);
    end else begin
      e = sb_q.pop_front();
      if (bus.led_code !== e.led) begin
        tests_failed++;
        $display("FAIL %s led_code edge %0d: got %b expected %b", cur_test, edge_cnt, bus.led_code, e.led);
      end
      tests_run++;
      if (bus.note_change !== e.nc) begin
        tests_failed++;
        $display("FAIL %s note_change edge %0d: got %b expected %b", cur_test, edge_cnt, bus.note_change, e.nc);
      end
    end
  endtask

  task automatic check_zero(input string what);
    tests_run++;
    if (bus.led_code !== '0 || bus.note_change !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s %s: got led_code %b note_change %b expected 0000000 0", cur_test, what, bus.led_code, bus.note_change);
    end
  endtask

  // Assert reset between clock edges, check outputs clear at once, release mid-cycle.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #2 check_zero("async_reset");
    bus.song_note = '0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_held");
    #2 rst_n = 1'b1;
    sb_q.delete();
    hist_q.delete();
    run_len   = 0;
    prev_note = 0;
    push_model(0, mode_next);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    apply_reset();
    repeat (3) step(0, 0);
  endtask

  task automatic test_onehot();
    int seq[6] = '{1, 4, 7, 0, 9, 0};
    cur_test = "onehot";
    foreach (seq[i]) step(seq[i], 0);
    step(0, 0);
  endtask

  task automatic test_bar();
    int seq[7] = '{3, 7, 0, 5, 1, 12, 0};
    cur_test = "bar";
    foreach (seq[i]) step(seq[i], 1);
    step(0, 1);
  endtask

  task automatic test_hold();
    cur_test = "hold_single";
    step(2, 2);
    repeat (8) step(0, 2);
    cur_test = "hold_reload";
    step(2, 2);
    repeat (2) step(0, 2);
    step(2, 2);
    repeat (8) step(0, 2);
    cur_test = "hold_multi";
    step(1, 2); step(7, 2); step(4, 2);
    repeat (7) step(0, 2);
  endtask

  task automatic test_chase();
    cur_test = "chase_walk";
    step(1, 3);
    repeat (IDLE + 2 * NN * STEP + 5) step(0, 3);
    cur_test = "chase_interrupt";
    step(5, 3);
    repeat (3) step(0, 3);
    cur_test = "chase_restart";
    repeat (IDLE + NN * STEP + 2) step(0, 3);
  endtask

  task automatic test_note_change();
    cur_test = "note_change";
    repeat (10) step(3, 0);
    step(6, 0); step(6, 0); step(0, 0); step(6, 1); step(13, 1); step(6, 1);
    step(0, 1);
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid_hold";
    step(4, 2); step(0, 2); step(0, 2);
    apply_reset();
    cur_test = "rest_after_reset";
    for (int m = 0; m < 3; m++) repeat (6) step(0, m);
    cur_test = "reset_mid_chase";
    repeat (IDLE + 5) step(0, 3);
    apply_reset();
    cur_test = "chase_after_reset";
    repeat (IDLE + 6) step(0, 3);
  endtask

  task automatic test_random();
    int note, m;
    cur_test = "random";
    m = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) m = $urandom_range(0, 3);
      note = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      if ($urandom_range(0, 40) == 0) repeat (IDLE + 4) step(0, m);
      step(note, m);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    edge_cnt      = 0;
    mode_next     = 0;
    run_len       = 0;
    prev_note     = 0;
    bus.song_note = '0;
    bus.mode      = '0;
    test_reset();
    test_onehot();
    test_bar();
    test_hold();
    test_chase();
    test_note_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
